// File: rtl/mem_readback_engine_if.sv
// Request, MIG command/return and client stream signals of mem_readback_engine.
// The master modport is the engine side; slave is the host/MIG/client side.
interface mem_readback_engine_if;
    logic         req_en;
    logic [28:0]  req_addr;
    logic [15:0]  req_len;
    logic         req_busy;
    logic         done;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic [255:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         rd_last;
    logic         err_unexpected;
    logic [31:0]  stall_cycles;

    modport master (
        input  req_en, req_addr, req_len, app_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, rd_ready,
        output req_busy, done, app_addr, app_cmd, app_en, rd_data, rd_valid, rd_last,
               err_unexpected, stall_cycles
    );

    modport slave (
        output req_en, req_addr, req_len, app_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, rd_ready,
        input  req_busy, done, app_addr, app_cmd, app_en, rd_data, rd_valid, rd_last,
               err_unexpected, stall_cycles
    );
endinterface

// File: rtl/mem_readback_engine.sv
// Linear MIG readback: issues credit-limited read commands and streams the returned
// beats through a FWFT FIFO. Define MEM_READBACK_PERF_EN to build the stall counter.
//
// state | meaning
// IDLE  | waiting for req_en
// ISSUE | issuing read commands while FIFO credit allows
// DRAIN | all commands issued, waiting for the client to take every beat
module mem_readback_engine #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_STEP  = 8
) (
    input  logic                  clk_ram,
    input  logic                  rst,
    mem_readback_engine_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          app_en_q, app_en_d;
    logic [28:0]   addr_q;
    logic [15:0]   remaining_q;
    logic [16:0]   total_q, delivered_q;
    logic [CW-1:0] outstanding_q, outstanding_nx;
    logic [CW-1:0] fifo_count_q, fifo_count_nx;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [255:0]  mem [FIFO_DEPTH];
    logic          done_zero_q, done_run, err_q;
    logic          start, start_run, cmd_acc, beat_wr, beat_rd, rd_valid;
    logic [CW:0]   load_nx;
    logic          credit_nx;

    assign start     = (state_q == IDLE) && bus.req_en;
    assign start_run = start && (bus.req_len != 16'd0);
    assign cmd_acc   = app_en_q && bus.app_rdy;
    assign beat_wr   = bus.app_rd_data_valid && (outstanding_q != '0);
    assign rd_valid  = (fifo_count_q != '0);
    assign beat_rd   = rd_valid && bus.rd_ready;

    always_comb begin
        outstanding_nx = outstanding_q;
        if (cmd_acc) outstanding_nx = outstanding_nx + CW'(2);
        if (beat_wr) outstanding_nx = outstanding_nx - CW'(1);
    end

    always_comb begin
        fifo_count_nx = fifo_count_q;
        if (beat_wr) fifo_count_nx = fifo_count_nx + CW'(1);
        if (beat_rd) fifo_count_nx = fifo_count_nx - CW'(1);
    end

    // app_en is registered, so credit is judged on the occupancy it will see next cycle
    assign load_nx   = {1'b0, outstanding_nx} + {1'b0, fifo_count_nx} + (CW+1)'(2);
    assign credit_nx = (load_nx <= (CW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d  = state_q;
        app_en_d = 1'b0;
        done_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_run) state_d = ISSUE;
            end
            ISSUE: begin
                if (cmd_acc && (remaining_q == 16'd1)) state_d = DRAIN;
                else if (app_en_q && !bus.app_rdy)    app_en_d = 1'b1;
                else                                   app_en_d = credit_nx;
            end
            DRAIN: begin
                if (delivered_q == total_q) begin
                    done_run = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state_q       <= IDLE;
            app_en_q      <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            total_q       <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            done_zero_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            app_en_q      <= app_en_d;
            done_zero_q   <= start && (bus.req_len == 16'd0);
            outstanding_q <= outstanding_nx;
            fifo_count_q  <= fifo_count_nx;
            if (beat_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (beat_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (bus.app_rd_data_valid && (outstanding_q == '0)) err_q <= 1'b1;
            if (start_run) begin
                addr_q      <= bus.req_addr;
                remaining_q <= bus.req_len;
                total_q     <= {bus.req_len, 1'b0};
                delivered_q <= '0;
            end else begin
                if (cmd_acc) begin
                    addr_q      <= addr_q + 29'(ADDR_STEP);
                    remaining_q <= remaining_q - 16'd1;
                end
                if (beat_rd) delivered_q <= delivered_q + 17'd1;
            end
        end
    end

    // MIG data cannot be stalled, so the FIFO write side never checks for full
    always_ff @(posedge clk_ram) begin
        if (beat_wr) mem[wr_ptr_q] <= bus.app_rd_data;
    end

`ifdef MEM_READBACK_PERF_EN
    logic [31:0] stall_q;
    logic [CW:0] load_now;
    logic        stall_evt;

    assign load_now  = {1'b0, outstanding_q} + {1'b0, fifo_count_q} + (CW+1)'(2);
    assign stall_evt = (app_en_q && !bus.app_rdy) ||
                       ((state_q == ISSUE) && !app_en_q && (load_now > (CW+1)'(FIFO_DEPTH)));

    always_ff @(posedge clk_ram) begin
        if (rst || start)                     stall_q <= '0;
        else if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif

    assign bus.req_busy       = (state_q != IDLE);
    assign bus.done           = done_run || done_zero_q;
    assign bus.app_addr       = addr_q;
    assign bus.app_cmd        = 3'b001;
    assign bus.app_en         = app_en_q;
    assign bus.rd_valid       = rd_valid;
    assign bus.rd_data        = rd_valid ? mem[rd_ptr_q] : '0;
    assign bus.rd_last        = rd_valid && (delivered_q == total_q - 17'd1);
    assign bus.err_unexpected = err_q;
endmodule

// File: doc/mem_readback_engine.md
# mem_readback_engine

Read-side companion to the capture write arbiter: takes one linear readback request (start address plus burst count) from the host-facing readout logic, issues MIG read commands, and returns the 256-bit read data as a valid/ready stream. Runs entirely in the controller clock domain. Outstanding reads are credit-limited against an internal data FIFO, because MIG read data cannot be back-pressured.

## Interface
Parameters:
- FIFO_DEPTH, 64: return-data FIFO depth in 256-bit words; power of two, at least 4.
- ADDR_STEP, 8: MIG address increment per read command.

Ports:
- clk_ram  in  1  controller clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_en  in  1  start pulse; sampled only in IDLE.
- req_addr  in  29  MIG address of the first burst.
- req_len  in  16  number of read commands; each command returns 2 data beats.
- req_busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the request completes.
- app_addr  out  29  MIG command address.
- app_cmd  out  3  constant 3'b001 (read).
- app_en  out  1  MIG command valid.
- app_rdy  in  1  MIG command accept.
- app_rd_data  in  256  MIG read data.
- app_rd_data_valid  in  1  MIG read data valid.
- app_rd_data_end  in  1  marks the second beat of a burst.
- rd_data  out  256  client data.
- rd_valid  out  1  client data valid.
- rd_ready  in  1  client accept.
- rd_last  out  1  final beat of the request; qualified by rd_valid.
- err_unexpected  out  1  sticky flag: read data arrived with nothing outstanding.
- stall_cycles  out  32  performance counter (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE
  - req_en with req_len != 0: latch the address, load remaining = req_len and total = 2*req_len, clear the delivered count, go to ISSUE.
  - req_en with req_len == 0: pulse done on the next cycle and stay in IDLE.
- ISSUE
  - A command is accepted when app_en && app_rdy.
  - While app_en is high, app_addr is held stable until acceptance.
  - Credit rule: app_en may assert only when outstanding + fifo_count + 2 <= FIFO_DEPTH. Here outstanding is the number of beats commanded but not yet returned, and fifo_count is the FIFO occupancy.
  - On acceptance: app_addr += ADDR_STEP (29-bit wrap modulo 2^29), remaining -= 1, outstanding += 2.
  - The acceptance with remaining == 1 moves the state to DRAIN and drops app_en on the next cycle.
- DRAIN
  - When delivered == total: pulse done, go to IDLE.
- Return path
  - Every app_rd_data_valid beat with outstanding > 0 is written to the FIFO and decrements outstanding.
  - A beat that arrives while outstanding == 0 is discarded and sets err_unexpected. The flag is cleared only by rst.
- Client side
  - A beat is delivered when rd_valid && rd_ready.
  - rd_last = rd_valid && (delivered == total-1).
- Simultaneous command acceptance and return beat in one cycle: outstanding changes by a net +1.
- req_en outside IDLE is ignored.
- app_rd_data_end is not used for counting; it feeds the ILA only.

## Timing
- Reset values: all outputs 0 except app_cmd = 3'b001. FIFO empty; outstanding, remaining and both counters cleared; state IDLE.
- req_en at cycle N → req_busy high and state ISSUE at N+1 → app_en high at N+2 if credit is available.
- While credit allows and app_rdy stays high, one command is accepted per cycle.
- The FIFO is first-word-fall-through: a beat written at cycle M shows rd_valid at M+1. Throughput is one beat per cycle.
- rd_data and rd_valid hold while rd_valid && !rd_ready.
- done is asserted the cycle after the final client handshake.
- Reset mid-request: the request is abandoned immediately and returns to IDLE. MIG data still in flight afterwards is dropped and sets err_unexpected. Host software must wait until the MIG is idle before asserting rst.

## Configuration
- MEM_READBACK_PERF_EN defined:
  - stall_cycles counts cycles with app_en && !app_rdy, plus cycles in ISSUE where app_en is held low by the credit rule.
  - It saturates at 2^32-1 and is cleared by rst and by each accepted req_en.
- Not defined: stall_cycles is tied to 0 and no counter logic is built.

## Test plan
- req_addr=0x100, req_len=4, app_rdy=1, MIG returns 2 beats per command after 20 cycles, rd_ready=1 → app_addr sequence 0x100/0x108/0x110/0x118; 8 beats delivered in order; rd_last on beat 8; done one cycle later.
- FIFO_DEPTH=8, req_len=16, rd_ready=0 → app_en stays low once outstanding+fifo_count reaches 8; no beat lost; releasing rd_ready completes all 32 beats.
- app_rdy toggling 1-of-3 cycles → app_addr stable while unaccepted; exactly req_len commands issued.
- req_len=0 → done pulses at N+1; app_en never asserts.
- app_rd_data_valid while idle → beat dropped; err_unexpected=1 and stays 1 until rst.
- With MEM_READBACK_PERF_EN, app_rdy held low for 10 cycles during ISSUE → stall_cycles=10.
